player_action_ctrl: RTL and testbench
=====================================

PLAYER_ACTION_CTRL -- requirements
Module: player_action_ctrl

Interface
REQ-001 Parameter CHARGE_MAX, default 31, maximum jump charge count; range 1..31.
REQ-002 Parameter VY_BASE, default 8, launch speed at zero charge.
REQ-003 Parameter VY_STEP, default 3, launch speed added per charge count.
REQ-004 Parameter WALK_SPEED, default 2, horizontal step per frame; range 1..7.
REQ-005 Port sys_clk, input, 1, single clock; all state changes occur on its rising edge.
REQ-006 Port sys_rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 Port frame_tick, input, 1, one-cycle pulse marking one game frame.
REQ-008 Ports left, right, jump, input, 1 each, debounced button levels.
REQ-009 Port on_ground, input, 1, high while the character rests on a platform.
REQ-010 Port sfx_ack, input, 1, sound engine accepts the pending request.
REQ-011 Port state, output, 2, current state: IDLE=0, WALK=1, CHARGE=2, AIR=3.
REQ-012 Port walk_valid, output, 1, one-cycle pulse; walk_dx is valid.
REQ-013 Port walk_dx, output, 4, signed two's-complement horizontal step.
REQ-014 Port launch, output, 1, one-cycle jump-launch pulse.
REQ-015 Port launch_vy, output, 8, unsigned launch speed; held until the next launch.
REQ-016 Port launch_dir, output, 2, {left,right} latched at launch; held until the next launch.
REQ-017 Port charge_level, output, 5, current charge count, for display.
REQ-018 Ports sfx_req, output, 1, and sfx_id, output, 2, sound request (1=JUMP, 2=LAND).

Function
REQ-019 State, charge and direction-latch changes occur only on cycles with frame_tick=1; the sfx handshake runs every cycle.
REQ-020 IDLE/WALK on tick, priority order: on_ground=0 -> AIR; else jump=1 -> CHARGE with charge=0; else exactly one of left/right -> WALK; else -> IDLE.
REQ-021 WALK on tick with on_ground=1, jump=0 and exactly one direction: walk_valid pulses that cycle; walk_dx = +WALK_SPEED for right, -WALK_SPEED for left.
REQ-022 Walk steps are issued only in WALK; the tick that enters WALK from IDLE also issues a step.
REQ-023 CHARGE on tick with on_ground=0 -> AIR, charge cleared, no launch, no sfx.
REQ-024 CHARGE on tick with jump=1 and charge<CHARGE_MAX: charge increments by 1; the direction latch loads {left,right}.
REQ-025 CHARGE on tick with jump=0, or with jump=1 and charge==CHARGE_MAX: launch pulses; launch_vy = min(255, VY_BASE + charge*VY_STEP), using at least 13-bit intermediate arithmetic; launch_dir = direction latch; JUMP sfx event; -> AIR; charge cleared.
REQ-026 Direction latch value {1,1} is passed through unchanged; it means vertical jump.
REQ-027 AIR on tick with on_ground=1 -> IDLE with LAND sfx event; all button inputs are ignored in AIR.
REQ-028 An sfx event sets sfx_req=1 and loads sfx_id; sfx_req stays high until the first cycle with sfx_ack=1, after which it is 0.
REQ-029 An event occurring while a request is pending overwrites sfx_id; sfx_req stays 1.
REQ-030 When sfx_ack=1 and a new event occur in the same cycle, the new event wins: sfx_req=1 with the new id.
REQ-031 frame_tick=0 with changing inputs produces no output pulse and no state change.

Reset
REQ-032 sys_rst_n=0 asynchronously forces: state=IDLE, charge=0, direction latch=0, walk_valid=0, walk_dx=0, launch=0, launch_vy=0, launch_dir=0, sfx_req=0, sfx_id=0.
REQ-033 Reset during CHARGE or AIR discards the charge and any pending sfx; there is no launch after release.
REQ-034 The first frame_tick after reset release is evaluated from IDLE.

Verification
REQ-035 on_ground=1, right=1 for 3 ticks -> state=WALK; 3 walk_valid pulses, each with walk_dx=+2; left only -> walk_dx=-2 (4'hE).
REQ-036 on_ground=1, jump held 5 ticks then released at tick 6 -> charge_level=4 before release; launch at tick 6 with launch_vy=8+4*3=20; sfx_req=1, sfx_id=1; state=AIR.
REQ-037 jump held 40 ticks -> auto-launch when charge==31, launch_vy=101, exactly one launch pulse; no further launch while AIR.
REQ-038 AIR, on_ground rises at a tick while sfx_ack is held 0 after a JUMP -> sfx_id becomes 2, sfx_req stays 1; sfx_ack pulse -> sfx_req=0 the next cycle.
REQ-039 CHARGE with on_ground dropping to 0 -> AIR, launch stays 0, charge_level=0.
REQ-040 sys_rst_n pulsed low mid-CHARGE with charge=7 -> all outputs at reset values immediately; no launch after release.

Source files
------------

// File: rtl/player_action_if.sv
// Frame-level control bundle between the game logic and the player action controller.
// The slave side is the controller; the master side drives the buttons and the sound acknowledge.
interface player_action_if;
   logic       frame_tick;
   logic       left;
   logic       right;
   logic       jump;
   logic       on_ground;
   logic       sfx_ack;
   logic [1:0] state;
   logic       walk_valid;
   logic [3:0] walk_dx;
   logic       launch;
   logic [7:0] launch_vy;
   logic [1:0] launch_dir;
   logic [4:0] charge_level;
   logic       sfx_req;
   logic [1:0] sfx_id;

   modport slave (
      input  frame_tick, left, right, jump, on_ground, sfx_ack,
      output state, walk_valid, walk_dx, launch, launch_vy, launch_dir,
             charge_level, sfx_req, sfx_id
   );

   modport master (
      output frame_tick, left, right, jump, on_ground, sfx_ack,
      input  state, walk_valid, walk_dx, launch, launch_vy, launch_dir,
             charge_level, sfx_req, sfx_id
   );
endinterface

// File: rtl/player_action_ctrl.sv
// Per-frame player movement FSM: walking, charged jumps, landing, and a
// single-slot sound request that always carries the most recent event.
module player_action_ctrl #(
   parameter int CHARGE_MAX = 31,
   parameter int VY_BASE    = 8,
   parameter int VY_STEP    = 3,
   parameter int WALK_SPEED = 2
) (
   input  logic           sys_clk,
   input  logic           sys_rst_n,
   player_action_if.slave ctrl
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WALK   = 2'd1,
      CHARGE = 2'd2,
      AIR    = 2'd3
   } state_t;

   localparam logic [1:0] SFX_JUMP   = 2'd1;
   localparam logic [1:0] SFX_LAND   = 2'd2;
   localparam logic [4:0] CHARGE_TOP = 5'(CHARGE_MAX);
   localparam logic [3:0] STEP_POS   = 4'(WALK_SPEED);
   localparam logic [3:0] STEP_NEG   = 4'(-WALK_SPEED);

   state_t     state_reg;
   logic [4:0] charge_reg;
   logic [1:0] dir_reg;
   logic       walk_valid_reg;
   logic [3:0] walk_dx_reg;
   logic       launch_reg;
   logic [7:0] launch_vy_reg;
   logic [1:0] launch_dir_reg;
   logic       sfx_req_reg;
   logic [1:0] sfx_id_reg;

   logic        one_dir;
   logic        keep_charging;
   logic [31:0] vy_wide;
   logic [7:0]  vy_sat;
   logic        sfx_event;
   logic [1:0]  sfx_event_id;

   assign one_dir       = ctrl.left ^ ctrl.right;
   assign keep_charging = ctrl.jump && (charge_reg < CHARGE_TOP);
   // Wide intermediate so large VY_STEP values saturate instead of wrapping.
   assign vy_wide = 32'(VY_BASE) + 32'(charge_reg) * 32'(VY_STEP);
   assign vy_sat  = (vy_wide > 32'd255) ? 8'hFF : vy_wide[7:0];

   always_comb begin
      sfx_event    = 1'b0;
      sfx_event_id = SFX_JUMP;
      if (ctrl.frame_tick && ctrl.on_ground) begin
         if (state_reg == CHARGE && !keep_charging) begin
            sfx_event = 1'b1;
         end else if (state_reg == AIR) begin
            sfx_event    = 1'b1;
            sfx_event_id = SFX_LAND;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_reg      <= IDLE;
         charge_reg     <= 5'd0;
         dir_reg        <= 2'd0;
         walk_valid_reg <= 1'b0;
         walk_dx_reg    <= 4'd0;
         launch_reg     <= 1'b0;
         launch_vy_reg  <= 8'd0;
         launch_dir_reg <= 2'd0;
         sfx_req_reg    <= 1'b0;
         sfx_id_reg     <= 2'd0;
      end else begin
         walk_valid_reg <= 1'b0;
         launch_reg     <= 1'b0;

         // A new event beats a simultaneous acknowledge.
         if (sfx_event) begin
            sfx_req_reg <= 1'b1;
            sfx_id_reg  <= sfx_event_id;
         end else if (ctrl.sfx_ack) begin
            sfx_req_reg <= 1'b0;
         end

         if (ctrl.frame_tick) begin
            case (state_reg)
               IDLE, WALK: begin
                  if (!ctrl.on_ground) begin
                     state_reg <= AIR;
                  end else if (ctrl.jump) begin
                     state_reg  <= CHARGE;
                     charge_reg <= 5'd0;
                  end else if (one_dir) begin
                     state_reg      <= WALK;
                     walk_valid_reg <= 1'b1;
                     walk_dx_reg    <= ctrl.right ? STEP_POS : STEP_NEG;
                  end else begin
                     state_reg <= IDLE;
                  end
               end
               CHARGE: begin
                  if (!ctrl.on_ground) begin
                     state_reg  <= AIR;
                     charge_reg <= 5'd0;
                  end else if (keep_charging) begin
                     charge_reg <= charge_reg + 5'd1;
                     dir_reg    <= {ctrl.left, ctrl.right};
                  end else begin
                     launch_reg     <= 1'b1;
                     launch_vy_reg  <= vy_sat;
                     launch_dir_reg <= dir_reg;
                     state_reg      <= AIR;
                     charge_reg     <= 5'd0;
                  end
               end
               AIR: begin
                  if (ctrl.on_ground) state_reg <= IDLE;
               end
               default: state_reg <= IDLE;
            endcase
         end
      end
   end

   assign ctrl.state        = state_reg;
   assign ctrl.walk_valid   = walk_valid_reg;
   assign ctrl.walk_dx      = walk_dx_reg;
   assign ctrl.launch       = launch_reg;
   assign ctrl.launch_vy    = launch_vy_reg;
   assign ctrl.launch_dir   = launch_dir_reg;
   assign ctrl.charge_level = charge_reg;
   assign ctrl.sfx_req      = sfx_req_reg;
   assign ctrl.sfx_id       = sfx_id_reg;
endmodule

// File: tb/tb_player_action_ctrl.sv
// Scoreboard bench for player_action_ctrl: directed scenarios followed by random
// frames, all checked against a behavioural model of the game rules.
module tb_player_action_ctrl;
   localparam int CHARGE_MAX = 31;
   localparam int VY_BASE    = 8;
   localparam int VY_STEP    = 3;
   localparam int WALK_SPEED = 2;

   typedef struct {
      int vy;
      int dir;
   } launch_t;

   logic clk;
   logic rst_n;
   player_action_if bus();

   player_action_ctrl #(
      .CHARGE_MAX (CHARGE_MAX),
      .VY_BASE    (VY_BASE),
      .VY_STEP    (VY_STEP),
      .WALK_SPEED (WALK_SPEED)
   ) dut (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .ctrl      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int launch_seen = 0;

   // Behavioural model: mode names follow the published state numbering.
   int m_mode;
   int m_charge;
   int m_dir;
   int m_req;
   int m_id;
   int walk_q[$];
   launch_t launch_q[$];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_charge = 0; m_dir = 0; m_req = 0; m_id = 0;
      walk_q.delete();
      launch_q.delete();
   endtask

   // Applies one clock's worth of game rules to the inputs the DUT just sampled.
   task automatic model_step();
      int ev_id;
      int vy;
      launch_t lr;
      ev_id = 0;
      if (bus.frame_tick) begin
         if (m_mode == 3) begin
            if (bus.on_ground) begin
               m_mode = 0;
               ev_id = 2;
            end
         end else if (m_mode == 2) begin
            if (!bus.on_ground) begin
               m_mode = 3; m_charge = 0;
            end else if (bus.jump && m_charge < CHARGE_MAX) begin
               m_charge = m_charge + 1;
               m_dir = 2 * int'(bus.left) + int'(bus.right);
            end else begin
               vy = VY_BASE + m_charge * VY_STEP;
               if (vy > 255) vy = 255;
               lr.vy = vy;
               lr.dir = m_dir;
               launch_q.push_back(lr);
               ev_id = 1;
               m_mode = 3; m_charge = 0;
            end
         end else begin
            if (!bus.on_ground) m_mode = 3;
            else if (bus.jump) begin
               m_mode = 2; m_charge = 0;
            end else if (bus.left != bus.right) begin
               m_mode = 1;
               walk_q.push_back(bus.right ? WALK_SPEED : 16 - WALK_SPEED);
            end else m_mode = 0;
         end
      end
      if (ev_id != 0) begin
         m_req = 1; m_id = ev_id;
      end else if (bus.sfx_ack) m_req = 0;
   endtask

   // Monitor: per-cycle state checks plus pulse-triggered scoreboard pops.
   always @(negedge clk) begin
      launch_t lx;
      int wx;
      chk("state", int'(bus.state), m_mode);
      chk("charge_level", int'(bus.charge_level), m_charge);
      chk("sfx_req", int'(bus.sfx_req), m_req);
      chk("sfx_id", int'(bus.sfx_id), m_id);
      chk("walk_valid", int'(bus.walk_valid), int'(walk_q.size() != 0));
      if (bus.walk_valid && walk_q.size() != 0) begin
         wx = walk_q.pop_front();
         chk("walk_dx", int'(bus.walk_dx), wx);
      end
      chk("launch", int'(bus.launch), int'(launch_q.size() != 0));
      if (bus.launch) launch_seen++;
      if (bus.launch && launch_q.size() != 0) begin
         lx = launch_q.pop_front();
         chk("launch_vy", int'(bus.launch_vy), lx.vy);
         chk("launch_dir", int'(bus.launch_dir), lx.dir);
      end
   end

   task automatic cyc(input bit t, input bit l, input bit r, input bit j, input bit g, input bit a);
      bus.frame_tick = t; bus.left = l; bus.right = r;
      bus.jump = j; bus.on_ground = g; bus.sfx_ack = a;
      @(posedge clk);
      if (rst_n) model_step();
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_state"}, int'(bus.state), 0);
      chk({tag, "_charge"}, int'(bus.charge_level), 0);
      chk({tag, "_walk_valid"}, int'(bus.walk_valid), 0);
      chk({tag, "_walk_dx"}, int'(bus.walk_dx), 0);
      chk({tag, "_launch"}, int'(bus.launch), 0);
      chk({tag, "_launch_vy"}, int'(bus.launch_vy), 0);
      chk({tag, "_launch_dir"}, int'(bus.launch_dir), 0);
      chk({tag, "_sfx_req"}, int'(bus.sfx_req), 0);
      chk({tag, "_sfx_id"}, int'(bus.sfx_id), 0);
   endtask

   task automatic do_reset(input string tag, input int hold);
      rst_n = 1'b0;
      model_reset();
      #1;
      check_reset_outputs(tag);
      repeat (hold) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      bit l, r, j, g;
      rst_n = 1'b1;
      bus.frame_tick = 0; bus.left = 0; bus.right = 0;
      bus.jump = 0; bus.on_ground = 1; bus.sfx_ack = 0;
      model_reset();
      #2;
      do_reset("rst0", 3);

      // Walk right three frames with untimed input noise between ticks, then left.
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 1, 0, 1, 0);
         cyc(0, 1, 0, 1, 0, 1);
      end
      chk("walk_state", int'(bus.state), 1);
      cyc(1, 1, 0, 0, 1, 0);
      cyc(1, 1, 0, 0, 1, 0);
      chk("walk_dx_left", int'(bus.walk_dx), 14);
      cyc(1, 0, 0, 0, 1, 0);

      // Charge five frames, release on the sixth.
      for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1, 1, 0);
      chk("charge4", int'(bus.charge_level), 4);
      cyc(1, 0, 0, 0, 1, 0);
      chk("vy20", int'(bus.launch_vy), 20);
      chk("air_after_launch", int'(bus.state), 3);
      chk("jump_sfx_id", int'(bus.sfx_id), 1);

      // Landing while the jump sound is still pending replaces it.
      cyc(1, 0, 0, 0, 1, 0);
      chk("land_sfx_id", int'(bus.sfx_id), 2);
      chk("land_sfx_req", int'(bus.sfx_req), 1);
      cyc(0, 0, 0, 0, 1, 1);
      chk("sfx_acked", int'(bus.sfx_req), 0);

      // Long hold: auto-launch at full charge, exactly once in the window.
      launch_seen = 0;
      for (int i = 0; i < 40; i++) begin
         cyc(1, i[0], 1, 1, 1, 1);
         if (i == 31) chk("charge_max", int'(bus.charge_level), 31);
         if (i == 32) chk("vy101", int'(bus.launch_vy), 101);
      end
      cyc(0, 0, 0, 1, 1, 0);
      chk("one_launch", launch_seen, 1);
      cyc(1, 0, 0, 0, 1, 0);

      // Ground lost mid-charge: no launch, charge dropped.
      cyc(1, 0, 0, 0, 1, 0);
      cyc(1, 0, 0, 1, 1, 0);
      cyc(1, 1, 1, 1, 1, 0);
      cyc(1, 0, 0, 1, 0, 0);
      chk("fall_state", int'(bus.state), 3);
      chk("fall_charge", int'(bus.charge_level), 0);
      cyc(1, 0, 0, 0, 1, 1);

      // Reset mid-charge at charge 7 discards everything.
      for (int i = 0; i < 8; i++) cyc(1, 0, 1, 1, 1, 1);
      chk("charge7", int'(bus.charge_level), 7);
      do_reset("rst_mid", 2);
      launch_seen = 0;
      for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 1, 0);
      chk("no_launch_after_reset", launch_seen, 0);

      // Random frames with slowly changing buttons.
      l = 0; r = 0; j = 0; g = 1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            l = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
         end
         if ($urandom_range(0, 11) == 0) j = ~j;
         if ($urandom_range(0, 9) == 0) g = ($urandom_range(0, 4) != 0);
         if ($urandom_range(0, 699) == 0) do_reset("rst_rand", 1);
         else cyc(1'($urandom_range(0, 1)), l, r, j, g, ($urandom_range(0, 3) == 0));
      end
      cyc(0, 0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
